// File: rtl/hex_scan_pkg.sv
// Shared constants for the multiplexed hex display driver: segment table,
// blank pattern and parameter legality limits.
package hex_scan_pkg;

  localparam int unsigned DIGITS_MIN   = 1;
  localparam int unsigned DIGITS_MAX   = 8;
  localparam int unsigned SCAN_DIV_MIN = 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit0 = a ... bit6 = g, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import hex_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_TABLE[nib];
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed hex display scanner with frame-synchronous value update
// (load/ready handshake into a pending register, committed at frame boundaries).
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] pending;
  logic                pending_valid;
  logic                tick;
  logic                boundary;
  logic [3:0]          nib;
  logic                blank;
  logic                above_zero;
  logic [6:0]          seg_dec;

  always_comb begin
    tick     = (presc == PRE_LAST);
    boundary = tick && (idx == IDX_LAST);
  end

  // Walk digits from the most significant down so above_zero tracks whether
  // every nibble from the top down to the current one is zero.
  always_comb begin
    above_zero = 1'b1;
    blank      = 1'b0;
    nib        = '0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      above_zero = above_zero && (shadow[4*(DIGITS-1-j) +: 4] == 4'h0);
      if (idx == IW'(DIGITS - 1 - j)) begin
        nib   = shadow[4*(DIGITS-1-j) +: 4];
        blank = blank_lz && (j != DIGITS - 1) && above_zero;
      end
    end
  end

  hex7seg u_dec (
    .nib   (nib),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc         <= '0;
      idx           <= '0;
      shadow        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      ready         <= 1'b1;
      frame         <= 1'b0;
      seg_n         <= SEG_BLANK;
      dig_n         <= '1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      frame <= boundary;
      // A commit and an accept never coincide: accept needs ready, which
      // is only high while nothing is pending.
      if (boundary && pending_valid) begin
        shadow        <= pending;
        pending_valid <= 1'b0;
        ready         <= 1'b1;
      end else if (load && ready) begin
        pending       <= value;
        pending_valid <= 1'b1;
        ready         <= 1'b0;
      end
      dig_n <= ~(DIGITS'(1) << idx);
      seg_n <= blank ? SEG_BLANK : seg_dec;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench for hex_scan_driver: a timing model pushes per-cycle
// expectations, each scenario task pops and compares them.
module tb_hex_scan_driver;

  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       frame;
    logic       ready;
  } exp_t;

  typedef struct packed {
    logic       dig;
    logic [6:0] seg;
    logic       frame;
    logic       ready;
  } exp2_t;

  logic        clock;
  logic        resetn, load, blank_lz, ready, frame;
  logic [15:0] value;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;

  logic        resetn2, load2, blank_lz2, ready2, frame2;
  logic [3:0]  value2;
  logic [6:0]  seg_n2;
  logic [0:0]  dig_n2;

  logic [6:0]  seg_tbl [16];
  exp_t        q[$];
  exp2_t       q2[$];
  int          n_cmp, n_bad;

  int unsigned m_e;
  logic [15:0] m_shadow, m_pend;
  logic        m_pvalid;

  hex_scan_driver #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .clock(clock), .resetn(resetn), .load(load), .value(value),
    .blank_lz(blank_lz), .ready(ready), .seg_n(seg_n), .dig_n(dig_n),
    .frame(frame)
  );

  hex_scan_driver #(.DIGITS(1), .SCAN_DIV(1)) dut2 (
    .clock(clock), .resetn(resetn2), .load(load2), .value(value2),
    .blank_lz(blank_lz2), .ready(ready2), .seg_n(seg_n2), .dig_n(dig_n2),
    .frame(frame2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; expectation derived from cycle count since reset release.
  task automatic tick();
    exp_t        x;
    int unsigned k;
    logic        bnd, acc;
    logic [3:0]  nb;
    @(posedge clock);
    if (!resetn) begin
      m_e = 0; m_shadow = '0; m_pend = '0; m_pvalid = 1'b0;
      x = '{dig: 4'hF, seg: 7'h7F, frame: 1'b0, ready: 1'b1};
    end else begin
      k   = (m_e / S) % D;
      bnd = ((m_e % (S*D)) == S*D - 1);
      nb  = 4'(m_shadow >> (4*k));
      x.dig   = ~(4'(1) << k);
      x.seg   = (blank_lz && k != 0 && (m_shadow >> (4*k)) == 16'h0) ? 7'h7F : seg_tbl[nb];
      x.frame = bnd;
      acc = load && !m_pvalid;
      if (bnd && m_pvalid) begin m_shadow = m_pend; m_pvalid = 1'b0; end
      if (acc) begin m_pend = value; m_pvalid = 1'b1; end
      x.ready = !m_pvalid;
      m_e++;
    end
    q.push_back(x);
    @(negedge clock);
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
  endtask

  task automatic test_scan();
    exp_t x;
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL scan cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
  endtask

  task automatic test_load();
    exp_t x;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin load = 1'b1; value = 16'h12AF; end
      else if (m_pvalid) begin load = 1'b1; value = 16'hFFFF; end
      else load = 1'b0;
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL load cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_blank();
    exp_t x;
    blank_lz = 1'b1;
    for (int i = 0; i < 64; i++) begin
      load = 1'b0;
      if (i == 0)  begin load = 1'b1; value = 16'h0030; end
      if (i == 32) begin load = 1'b1; value = 16'h0000; end
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL blank cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
    load = 1'b0;
    blank_lz = 1'b0;
  endtask

  task automatic test_load_on_boundary();
    exp_t x;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load = 1'b0;
      if (!done && !m_pvalid && (m_e % (S*D)) == S*D - 1) begin
        load = 1'b1; value = 16'h5A5A; done = 1'b1;
      end
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL boundary_load cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_pending();
    exp_t x;
    for (int i = 0; i < 27; i++) begin
      load = (i == 0);
      value = 16'h1234;
      if (i == 3) begin
        #1 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({dig_n, seg_n, frame, ready} !== {4'hF, 7'h7F, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL async_reset: got dig=%h seg=%h fr=%b rdy=%b exp dig=f seg=7f fr=0 rdy=1",
                   dig_n, seg_n, frame, ready);
        end
      end
      if (i == 6) resetn = 1'b1;
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL reset_pending cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 160; i++) begin
      load     = !m_pvalid && ($urandom_range(0, 3) != 0);
      value    = 16'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
      tick();
      x = q.pop_front();
      n_cmp++;
      if ({dig_n, seg_n, frame, ready} !== x) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d: got dig=%h seg=%h fr=%b rdy=%b exp dig=%h seg=%h fr=%b rdy=%b",
                 i, dig_n, seg_n, frame, ready, x.dig, x.seg, x.frame, x.ready);
      end
    end
    load = 1'b0;
    blank_lz = 1'b0;
  endtask

  task automatic test_single_digit();
    exp2_t      x;
    logic [3:0] s_shadow, s_pend;
    logic       s_pv, acc;
    s_shadow = '0; s_pend = '0; s_pv = 1'b0;
    resetn2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      load2  = (i == 2 || i == 6) && !s_pv;
      value2 = (i == 2) ? 4'h7 : 4'h0;
      @(posedge clock);
      x.dig   = 1'b0;
      x.seg   = seg_tbl[s_shadow];
      x.frame = 1'b1;
      acc = load2 && !s_pv;
      if (s_pv) begin s_shadow = s_pend; s_pv = 1'b0; end
      if (acc) begin s_pend = value2; s_pv = 1'b1; end
      x.ready = !s_pv;
      q2.push_back(x);
      @(negedge clock);
      x = q2.pop_front();
      n_cmp++;
      if ({dig_n2, seg_n2, frame2, ready2} !== x) begin
        n_bad++;
        $display("FAIL single_digit cyc%0d: got dig=%b seg=%h fr=%b rdy=%b exp dig=%b seg=%h fr=%b rdy=%b",
                 i, dig_n2, seg_n2, frame2, ready2, x.dig, x.seg, x.frame, x.ready);
      end
    end
    load2 = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    n_cmp = 0; n_bad = 0;
    m_e = 0; m_shadow = '0; m_pend = '0; m_pvalid = 1'b0;
    resetn = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0;
    resetn2 = 1'b0; load2 = 1'b0; value2 = '0; blank_lz2 = 1'b1;
    @(negedge clock);
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_load_on_boundary();
    test_reset_pending();
    test_back_to_back();
    test_single_digit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range >= 1.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  request to accept value.
REQ-006 value  input  4*DIGITS  hex value to display; nibble k drives digit k; digit 0 is least significant.
REQ-007 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-008 ready  output  1  1 = load will be accepted this cycle.
REQ-009 seg_n  output  7  active-low segments; bit0 = a ... bit6 = g.
REQ-010 dig_n  output  DIGITS  active-low one-hot digit enable.
REQ-011 frame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; tick is asserted when prescaler = SCAN_DIV-1; SCAN_DIV=1 gives a tick every cycle.
REQ-013 Digit index idx advances by 1 on each tick and wraps from DIGITS-1 to 0.
REQ-014 Frame boundary: tick while idx = DIGITS-1; frame is 1 for exactly the cycle following that boundary and 0 otherwise.
REQ-015 Handshake: load=1 while ready=1 captures value into the pending register, sets pending_valid, and drives ready=0 from the next cycle.
REQ-016 load while ready=0 is ignored; value is don't-care while load=0.
REQ-017 At a frame boundary with pending_valid=1, the shadow register takes pending and pending_valid clears; ready returns to 1 on the next cycle.
REQ-018 Load accepted on the same cycle as a frame boundary is committed at the next boundary, not the current one.
REQ-019 Displayed data changes only at frame boundaries (no tearing within a frame).
REQ-020 seg_n and dig_n are registered: both reflect idx and shadow with one cycle of latency; exactly one dig_n bit is 0 at all times after reset release.
REQ-021 Segment patterns (seg_n, hex) for nibble 0..F:
  0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-022 Blanking: when blank_lz=1, digit k>0 shows seg_n=7F if shadow nibbles DIGITS-1 down to k are all 0; digit 0 is never blanked.
REQ-023 blank_lz is sampled live, not buffered; it takes effect on the next registered output update.

Reset
REQ-024 While resetn=0: prescaler=0, idx=0, shadow=0, pending=0, pending_valid=0, ready=1, frame=0, seg_n=7F, dig_n all ones.
REQ-025 Reset asserted mid-operation discards any pending value immediately; no partial commit occurs.
REQ-026 The first clock edge after resetn rises drives dig_n bit0 = 0 and seg_n = 40.

Structure
REQ-027 Package hex_scan_pkg holds the 16-entry segment table, the SEG_BLANK constant (7F), and the DIGITS/SCAN_DIV legality limits.
REQ-028 One sub-module hex7seg (combinational 4-bit to 7-bit active-low decoder using the package table) is instantiated once, on the selected nibble.

Verification (DIGITS=4, SCAN_DIV=2 unless stated)
REQ-029 Reset release with no load -> dig_n walks E,D,B,7 with one step every 2 cycles; seg_n=40 on digit 0; frame pulses every 8 cycles.
REQ-030 load with value=16'h12AF, blank_lz=0 -> ready=0 until the next frame; the following frame shows F,A,2,1 (0E,08,24,79) on digits 0..3; ready=1 one cycle after commit.
REQ-031 Second load held while ready=0 (value=16'hFFFF) -> ignored; the display keeps 12AF.
REQ-032 value=16'h0030, blank_lz=1 -> digits 3 and 2 output seg_n=7F; digit 1 = 30, digit 0 = 40; value=0 -> only digit 0 lit (40).
REQ-033 load coincident with a frame boundary -> commit occurs one full frame (8 cycles) later; resetn pulsed while ready=0 -> display reverts to 0000 and ready=1.
REQ-034 DIGITS=1, SCAN_DIV=1 -> dig_n held at 0; frame pulses every cycle; load commits within 1 cycle.
